mac_tx_scheduler: RTL and testbench
===================================

MAC_TX_SCHEDULER -- requirements
Module: mac_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one mac_mii_top frame generator; valid range is 2..8.
REQ-002 Parameter PAYLOAD_MAX_SIZE, default 1500: the largest legal payload length in bytes.
REQ-003 Parameter IFG_CYCLES, default 2: the number of idle clocks enforced between frames.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: the clock budget from o_start rise to the fall of i_tx_valid.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port i_rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 Port i_req, input, N_REQ bits: per-requester frame request, held high until that requester's completion pulse.
REQ-008 Ports i_dest_address, input, N_REQ*48; i_src_address, input, N_REQ*48; i_eth_type, input, N_REQ*16; i_payload_length, input, N_REQ*16: per-requester header fields, with slice n belonging to requester n.
REQ-009 Port i_tx_valid, input, 1 bit: the generator's o_txValid, high while the frame is on MII.
REQ-010 Ports o_start, output, 1; o_dest_address, output, 48; o_src_address, output, 48; o_eth_type, output, 16; o_payload_length, output, 16: the drive to the generator.
REQ-011 Port o_sel, output, $clog2(N_REQ) bits: the granted index, used by the external payload mux.
REQ-012 Ports o_grant, o_done, o_reject and o_timeout, each output, N_REQ bits: o_grant is a one-hot level; o_done, o_reject and o_timeout are one-clock completion pulses.
REQ-013 Port o_busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, CHECK, START, TX, IFG.
REQ-015 In IDLE, when any i_req is high, the block SHALL select the winner round-robin, starting the search at index ptr and wrapping at N_REQ.
  - It SHALL register o_grant, o_sel and all header fields from the winner's slices.
  - It SHALL then go to CHECK.
REQ-016 In CHECK, if the latched length is 0 or greater than PAYLOAD_MAX_SIZE, the block SHALL pulse o_reject[sel] for one clock, clear o_grant and go to IDLE.
  - Otherwise it SHALL go to START.
REQ-017 In START, o_start SHALL be high.
  - On the first cycle with i_tx_valid=1, o_start SHALL drop and the FSM SHALL go to TX.
REQ-018 In TX, on the first cycle with i_tx_valid=0, the block SHALL pulse o_done[sel] for one clock, clear o_grant and go to IFG.
REQ-019 IFG SHALL last exactly IFG_CYCLES clocks and then return to IDLE; with IFG_CYCLES=0 it SHALL pass through in one clock.
REQ-020 Latency SHALL be:
  - i_req sampled in IDLE at cycle k gives o_grant at k+1 and o_start at k+2.
  - The next frame's o_start comes at the earliest IFG_CYCLES+3 clocks after o_done.
REQ-021 ptr SHALL become (sel+1) mod N_REQ on every o_done, o_reject or o_timeout pulse.
REQ-022 A timeout counter SHALL count from START entry, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES in START or TX, the block SHALL pulse o_timeout[sel], force o_start=0, clear o_grant and go to IFG.
  - No o_done SHALL be issued for that frame.
REQ-023 Header outputs SHALL stay stable from CHECK until leaving TX; i_req and field changes after the grant SHALL be ignored.
REQ-024 A requester dropping i_req after its grant SHALL NOT abort the frame.
REQ-025 In the same IDLE cycle, only the winner SHALL be granted; other requests wait, with no starvation beyond N_REQ-1 frames.
REQ-026 At most one bit in o_grant/o_done/o_reject/o_timeout SHALL be set at a time; o_done, o_reject and o_timeout SHALL be mutually exclusive.
REQ-027 If i_tx_valid is already high on START entry, the block SHALL treat it as the frame start: it moves to TX next clock.

Reset
REQ-028 While i_rst_n=0, the following SHALL be zero, asynchronously, including mid-frame:
  - state=IDLE, ptr=0, timeout counter 0, IFG counter 0;
  - o_start, o_grant, o_done, o_reject, o_timeout, o_busy;
  - o_sel and all header outputs.
REQ-029 The first arbitration after release SHALL happen on the first rising edge with i_rst_n=1.

Structure
REQ-030 Package mac_sched_pkg SHALL hold the state enum, the ETH header widths (48/16) and the default IFG/timeout constants.
REQ-031 Round-robin selection SHALL live in sub-module rr_arbiter (inputs: req, ptr; outputs: one-hot grant, index, any), which is purely combinational.
REQ-032 The block SHALL contain no payload storage; payload muxing stays outside, keyed on o_sel.

Verification
REQ-033 Single request: i_req=4'b0001 with length 8 and a generator model holding i_tx_valid for 6 clocks.
  - Required: o_start at k+2, o_done[0] one clock after i_tx_valid falls, ptr=1.
REQ-034 All four requesting continuously: grants SHALL follow the order 0,1,2,3,0, with gaps ≥ IFG_CYCLES between o_done and the next o_grant.
REQ-035 Length checks on requester 2:
  - length 0 gives o_reject[2] with no o_start;
  - length 1501 gives o_reject[2];
  - length 1500 proceeds to o_start.
REQ-036 Generator never asserting i_tx_valid: o_timeout[sel] SHALL pulse exactly TIMEOUT_CYCLES clocks after START entry, followed by an IFG, and the next requester SHALL then be served.
REQ-037 i_rst_n pulsed low during TX: all outputs zero within the same time step; after release, requester 0 is served first.
REQ-038 Header fields of the granted requester changed during TX: the o_dest_address/o_eth_type/o_payload_length outputs SHALL stay unchanged, and o_sel SHALL stay stable.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared state type, Ethernet header widths and default timing for the MAC TX scheduler
package mac_sched_pkg;

  localparam int MAC_W              = 48;
  localparam int TYPE_W             = 16;
  localparam int DEF_IFG_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_TX,
    S_IFG
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr and wrapping at N
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] index,
  output logic         any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        index    = W'(j);
      end
    end
  end

endmodule

// File: rtl/mac_tx_scheduler.sv
// rtl/mac_tx_scheduler.sv - arbitrates N requesters onto one frame generator with length check, timeout and IFG
module mac_tx_scheduler
  import mac_sched_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int IFG_CYCLES       = DEF_IFG_CYCLES,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*MAC_W-1:0]     i_dest_address,
  input  logic [N_REQ*MAC_W-1:0]     i_src_address,
  input  logic [N_REQ*TYPE_W-1:0]    i_eth_type,
  input  logic [N_REQ*TYPE_W-1:0]    i_payload_length,
  input  logic                       i_tx_valid,
  output logic                       o_start,
  output logic [MAC_W-1:0]           o_dest_address,
  output logic [MAC_W-1:0]           o_src_address,
  output logic [TYPE_W-1:0]          o_eth_type,
  output logic [TYPE_W-1:0]          o_payload_length,
  output logic [$clog2(N_REQ)-1:0]   o_sel,
  output logic [N_REQ-1:0]           o_grant,
  output logic [N_REQ-1:0]           o_done,
  output logic [N_REQ-1:0]           o_reject,
  output logic [N_REQ-1:0]           o_timeout,
  output logic                       o_busy
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IFG_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_next;
  logic [TO_W-1:0]    tcnt;
  logic [IFG_W-1:0]   icnt;
  logic [N_REQ-1:0]   win_grant;
  logic [SEL_W-1:0]   win_idx;
  logic               win_any;
  logic               bad_len, to_hit, ifg_end;
  logic               do_load, do_reject, do_done, do_tout;

  rr_arbiter #(.N(N_REQ), .W(SEL_W)) u_arb (
    .req   (i_req),
    .ptr   (ptr),
    .grant (win_grant),
    .index (win_idx),
    .any   (win_any)
  );

  assign bad_len  = (o_payload_length == '0) || (o_payload_length > TYPE_W'(PAYLOAD_MAX_SIZE));
  assign to_hit   = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
  // IFG holds IFG_CYCLES idle clocks after the completion-pulse clock
  assign ifg_end  = (icnt == IFG_W'(IFG_CYCLES));
  assign ptr_next = (o_sel == SEL_W'(N_REQ - 1)) ? '0 : o_sel + 1'b1;
  assign o_start  = (state == S_START);
  assign o_busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_load   = 1'b0;
    do_reject = 1'b0;
    do_done   = 1'b0;
    do_tout   = 1'b0;
    case (state)
      S_IDLE: if (win_any) begin
        do_load = 1'b1;
        state_n = S_CHECK;
      end
      S_CHECK: if (bad_len) begin
        do_reject = 1'b1;
        state_n   = S_IDLE;
      end else begin
        state_n = S_START;
      end
      S_START: if (to_hit) begin
        do_tout = 1'b1;
        state_n = S_IFG;
      end else if (i_tx_valid) begin
        state_n = S_TX;
      end
      S_TX: if (to_hit) begin
        do_tout = 1'b1;
        state_n = S_IFG;
      end else if (!i_tx_valid) begin
        do_done = 1'b1;
        state_n = S_IFG;
      end
      S_IFG: if (ifg_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr              <= '0;
      tcnt             <= '0;
      icnt             <= '0;
      o_sel            <= '0;
      o_grant          <= '0;
      o_done           <= '0;
      o_reject         <= '0;
      o_timeout        <= '0;
      o_dest_address   <= '0;
      o_src_address    <= '0;
      o_eth_type       <= '0;
      o_payload_length <= '0;
    end else begin
      o_done    <= do_done   ? o_grant : '0;
      o_reject  <= do_reject ? o_grant : '0;
      o_timeout <= do_tout   ? o_grant : '0;
      if (do_load) begin
        o_grant          <= win_grant;
        o_sel            <= win_idx;
        o_dest_address   <= i_dest_address[win_idx*MAC_W +: MAC_W];
        o_src_address    <= i_src_address[win_idx*MAC_W +: MAC_W];
        o_eth_type       <= i_eth_type[win_idx*TYPE_W +: TYPE_W];
        o_payload_length <= i_payload_length[win_idx*TYPE_W +: TYPE_W];
      end
      if (do_done || do_reject || do_tout) begin
        o_grant <= '0;
        ptr     <= ptr_next;
      end
      if (state == S_CHECK)
        tcnt <= '0;
      else if ((state == S_START || state == S_TX) && tcnt != TO_W'(TIMEOUT_CYCLES))
        tcnt <= tcnt + 1'b1;
      icnt <= (state == S_IFG && !ifg_end) ? icnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb/tb_mac_tx_scheduler.sv - scoreboard bench for mac_tx_scheduler
`timescale 1ns/1ps
module tb_mac_tx_scheduler;

  localparam int N      = 4;
  localparam int IFG    = 2;
  localparam int TO     = 1024;
  localparam int K_DONE = 1;
  localparam int K_REJ  = 2;
  localparam int K_TO   = 3;

  logic            clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    i_req;
  logic [N*48-1:0] i_dest_address;
  logic [N*48-1:0] i_src_address;
  logic [N*16-1:0] i_eth_type;
  logic [N*16-1:0] i_payload_length;
  logic            i_tx_valid;
  logic            o_start;
  logic [47:0]     o_dest_address;
  logic [47:0]     o_src_address;
  logic [15:0]     o_eth_type;
  logic [15:0]     o_payload_length;
  logic [1:0]      o_sel;
  logic [N-1:0]    o_grant;
  logic [N-1:0]    o_done;
  logic [N-1:0]    o_reject;
  logic [N-1:0]    o_timeout;
  logic            o_busy;

  mac_tx_scheduler #(
    .N_REQ(N), .PAYLOAD_MAX_SIZE(1500), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req),
    .i_dest_address(i_dest_address), .i_src_address(i_src_address),
    .i_eth_type(i_eth_type), .i_payload_length(i_payload_length),
    .i_tx_valid(i_tx_valid), .o_start(o_start),
    .o_dest_address(o_dest_address), .o_src_address(o_src_address),
    .o_eth_type(o_eth_type), .o_payload_length(o_payload_length),
    .o_sel(o_sel), .o_grant(o_grant), .o_done(o_done), .o_reject(o_reject),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_q[$];
  int   n_comp  = 0;
  int   n_start = 0;
  int   t_grant, t_start, t_comp, t_vfall, g_idx, last_kind;
  logic prev_g, prev_s, prev_v;
  logic gap_chk;
  logic gen_en;
  int   gen_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] dest_of(input int n);
    return 48'hD0D0_0000_0000 | 48'(n);
  endfunction

  function automatic logic [15:0] type_of(input int n);
    return 16'h0800 | 16'(n);
  endfunction

  // Generator model: raises valid on the first o_start it sees and holds it gen_hold clocks
  initial begin
    int gcnt;
    gcnt       = 0;
    i_tx_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!i_rst_n) begin
        i_tx_valid = 1'b0;
        gcnt       = 0;
      end else if (gcnt > 0) begin
        gcnt--;
        if (gcnt == 0) i_tx_valid = 1'b0;
      end else if (o_start && gen_en) begin
        i_tx_valid = 1'b1;
        gcnt       = gen_hold;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] pulses;
    int kinds, kind, idx, obs;
    if (!i_rst_n) begin
      prev_g    = 1'b0;
      prev_s    = 1'b0;
      prev_v    = 1'b0;
      last_kind = 0;
    end else begin
      if (o_grant != '0 && !prev_g) begin
        t_grant = cyc;
        g_idx   = int'(o_sel);
        chk("grant_onehot", 64'(o_grant), 64'(1) << o_sel);
        if (last_kind == K_DONE || last_kind == K_TO)
          chk("ifg_gap", 64'((cyc - t_comp - 1) >= IFG), 64'd1);
      end
      if (o_start && !prev_s) begin
        t_start = cyc;
        n_start++;
        if (gap_chk && last_kind == K_DONE)
          chk("restart_lat", 64'(cyc - t_comp), 64'(IFG + 3));
      end
      if (!i_tx_valid && prev_v) t_vfall = cyc;
      pulses = o_done | o_reject | o_timeout;
      if (pulses != '0) begin
        kinds = int'(o_done != '0) + int'(o_reject != '0) + int'(o_timeout != '0);
        kind  = (o_done != '0) ? K_DONE : (o_reject != '0) ? K_REJ : K_TO;
        idx   = 0;
        for (int i = 0; i < N; i++) if (pulses[i]) idx = i;
        obs = ($countones(pulses) != 1 || kinds != 1) ? 'hFFFF : kind * 16 + idx;
        if (exp_q.size() == 0) chk("sb_unexpected", 64'(obs), 64'd0);
        else                   chk("sb_completion", 64'(obs), 64'(exp_q.pop_front()));
        n_comp++;
        t_comp    = cyc;
        last_kind = kind;
      end
      prev_g = (o_grant != '0);
      prev_s = o_start;
      prev_v = i_tx_valid;
    end
  end

  task automatic wait_comp(input int target, input int budget);
    int b;
    b = 0;
    while (n_comp < target && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    if (n_comp < target) chk("wait_budget", 64'(n_comp), 64'(target));
  endtask

  task automatic wait_valid(input int budget);
    int b;
    b = 0;
    while (!i_tx_valid && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (!i_tx_valid) chk("wait_valid", 64'(i_tx_valid), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue_drop(input logic [N-1:0] mask);
    @(posedge clk); #1;
    i_req = mask;
    @(posedge clk); #1;
    i_req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k, c, ns, n0;
    i_rst_n  = 1'b0;
    i_req    = '0;
    gen_en   = 1'b1;
    gen_hold = 6;
    gap_chk  = 1'b0;
    for (int n = 0; n < N; n++) begin
      i_dest_address[n*48 +: 48]   = dest_of(n);
      i_src_address[n*48 +: 48]    = 48'h5A5A_0000_0000 | 48'(n);
      i_eth_type[n*16 +: 16]       = type_of(n);
      i_payload_length[n*16 +: 16] = 16'd8;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({o_start, o_busy, o_grant, o_done, o_reject, o_timeout, o_sel}), 64'd0);
    chk("rst_hdr_da", 64'(o_dest_address), 64'd0);
    chk("rst_hdr_sa", 64'(o_src_address), 64'd0);
    chk("rst_hdr_tl", 64'({o_eth_type, o_payload_length}), 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;

    // single request, held until done
    @(posedge clk); #1;
    n0    = n_comp;
    i_req = 4'b0001;
    k     = cyc;
    exp_q.push_back(K_DONE * 16 + 0);
    wait_comp(n0 + 1, 200);
    chk("single_grant_lat", 64'(t_grant), 64'(k + 1));
    chk("single_start_lat", 64'(t_start), 64'(k + 2));
    chk("single_done_after_fall", 64'(t_comp - t_vfall), 64'd1);
    chk("single_ptr", 64'(dut.ptr), 64'd1);
    chk("single_da", 64'(o_dest_address), 64'(dest_of(0)));
    chk("single_len", 64'(o_payload_length), 64'd8);
    i_req = '0;
    repeat (6) @(negedge clk);

    // all four requesting continuously from a fresh pointer
    do_reset();
    gen_hold = 3;
    gap_chk  = 1'b1;
    n0       = n_comp;
    i_req    = 4'b1111;
    exp_q.push_back(K_DONE * 16 + 0);
    exp_q.push_back(K_DONE * 16 + 1);
    exp_q.push_back(K_DONE * 16 + 2);
    exp_q.push_back(K_DONE * 16 + 3);
    exp_q.push_back(K_DONE * 16 + 0);
    wait_comp(n0 + 5, 400);
    i_req   = '0;
    gap_chk = 1'b0;
    repeat (6) @(negedge clk);

    // length boundaries on requester 2; request dropped right after grant
    i_payload_length[2*16 +: 16] = 16'd0;
    ns = n_start; n0 = n_comp;
    exp_q.push_back(K_REJ * 16 + 2);
    issue_drop(4'b0100);
    wait_comp(n0 + 1, 50);
    repeat (6) @(negedge clk);
    chk("len0_no_start", 64'(n_start), 64'(ns));

    i_payload_length[2*16 +: 16] = 16'd1501;
    ns = n_start; n0 = n_comp;
    exp_q.push_back(K_REJ * 16 + 2);
    issue_drop(4'b0100);
    wait_comp(n0 + 1, 50);
    repeat (6) @(negedge clk);
    chk("len1501_no_start", 64'(n_start), 64'(ns));

    i_payload_length[2*16 +: 16] = 16'd1500;
    gen_hold = 4;
    ns = n_start; n0 = n_comp;
    exp_q.push_back(K_DONE * 16 + 2);
    issue_drop(4'b0100);
    wait_comp(n0 + 1, 100);
    chk("len1500_started", 64'(n_start - ns), 64'd1);
    repeat (6) @(negedge clk);

    // silent generator: timeout on requester 0, then requester 1 is served
    gen_en = 1'b0;
    n0     = n_comp;
    exp_q.push_back(K_TO * 16 + 0);
    exp_q.push_back(K_DONE * 16 + 1);
    @(posedge clk); #1;
    i_req = 4'b0011;
    wait_comp(n0 + 1, TO + 100);
    chk("timeout_lat", 64'(t_comp - t_start), 64'(TO));
    i_req  = 4'b0010;
    gen_en = 1'b1;
    wait_comp(n0 + 2, 200);
    chk("after_timeout_idx", 64'(g_idx), 64'd1);
    i_req = '0;
    repeat (6) @(negedge clk);

    // header fields of the granted requester change mid-TX
    i_payload_length[3*16 +: 16] = 16'd20;
    gen_hold = 10;
    n0       = n_comp;
    exp_q.push_back(K_DONE * 16 + 3);
    @(posedge clk); #1;
    i_req = 4'b1000;
    wait_valid(50);
    repeat (2) @(negedge clk);
    i_dest_address[3*48 +: 48]   = 48'h1234_5678_9ABC;
    i_eth_type[3*16 +: 16]       = 16'hBEEF;
    i_payload_length[3*16 +: 16] = 16'd99;
    @(negedge clk);
    chk("hold_da", 64'(o_dest_address), 64'(dest_of(3)));
    chk("hold_et", 64'(o_eth_type), 64'(type_of(3)));
    chk("hold_len", 64'(o_payload_length), 64'd20);
    chk("hold_sel", 64'(o_sel), 64'd3);
    wait_comp(n0 + 1, 100);
    i_req = '0;
    i_dest_address[3*48 +: 48] = dest_of(3);
    i_eth_type[3*16 +: 16]     = type_of(3);
    repeat (6) @(negedge clk);

    // move ptr to 2, start a frame for requester 2, reset it mid-TX
    n0 = n_comp;
    exp_q.push_back(K_DONE * 16 + 1);
    issue_drop(4'b0010);
    wait_comp(n0 + 1, 100);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    i_req = 4'b0101;
    wait_valid(50);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({o_start, o_busy, o_grant, o_done, o_reject, o_timeout, o_sel}), 64'd0);
    chk("rst_mid_hdr", 64'(o_dest_address | o_src_address), 64'd0);
    chk("rst_mid_tl", 64'({o_eth_type, o_payload_length}), 64'd0);
    chk("rst_mid_ptr", 64'(dut.ptr), 64'd0);
    repeat (2) @(negedge clk);
    n0 = n_comp;
    exp_q.push_back(K_DONE * 16 + 0);
    i_rst_n = 1'b1;
    c = cyc;
    wait_comp(n0 + 1, 200);
    i_req = '0;
    chk("rst_first_idx", 64'(g_idx), 64'd0);
    chk("rst_first_grant", 64'(t_grant), 64'(c + 1));

    repeat (10) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
